// File: rtl/uart_pkg.sv
// Shared UART definitions: check-mode encodings, receiver state encoding
// and the expected-parity helper used by both the receiver and transmitter.
package uart_pkg;

    localparam int CHK_NONE = 0;
    localparam int CHK_EVEN = 1;
    localparam int CHK_ODD  = 2;
    localparam int CHK_ZERO = 3;
    localparam int CHK_ONE  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Data is zero-extended to 9 bits, which leaves its XOR unchanged.
    function automatic logic parity_bit(input int mode, input logic [8:0] data);
        case (mode)
            CHK_EVEN: return ^data;
            CHK_ODD:  return ~^data;
            CHK_ONE:  return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every CLK_DIV clocks,
// held at phase zero while clear is high.
module uart_baud_tick #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_W'(CLK_DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote bit sampling, parity and
// stop checking, break detection and a single-entry valid/ready output.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 27,
    parameter int OS_RATE    = 16,
    parameter int DATA_BITS  = 8,
    parameter int CHECK_MODE = 1,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("uart_rx_os: CLK_DIV must be >= 1");
    end
    if (OS_RATE < 8 || OS_RATE > 32 || (OS_RATE % 2) != 0) begin : g_bad_os_rate
        $error("uart_rx_os: OS_RATE must be even and in 8..32");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be in 5..9");
    end
    if (CHECK_MODE < 0 || CHECK_MODE > 4) begin : g_bad_check_mode
        $error("uart_rx_os: CHECK_MODE must be in 0..4");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_rx_os: STOP_BITS must be 1 or 2");
    end

    localparam int OS_W = $clog2(OS_RATE);
    localparam logic [OS_W-1:0] SAMP0   = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0] SAMP1   = OS_W'(OS_RATE / 2);
    localparam logic [OS_W-1:0] SAMP2   = OS_W'(OS_RATE / 2 + 1);
    localparam logic [OS_W-1:0] BIT_END = OS_W'(OS_RATE - 1);

    logic rx_meta, rx_sync, rx_prev;
    logic tick;

    rx_state_t              state;
    logic [OS_W-1:0]        os_cnt;
    logic [3:0]             bit_idx;
    logic                   stop_idx;
    logic                   samp_a, samp_b;
    logic [DATA_BITS-1:0]   data_sr;
    logic                   par_err_r, frm_err_r, all_zero;

    logic at_maj, at_end, maj, frame_bad, is_break, last_stop;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (~rx_en),
        .tick  (tick)
    );

    // rx_prev trails the synchronised line by one clock for start-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign at_maj    = tick && (os_cnt == SAMP2);
    assign at_end    = tick && (os_cnt == BIT_END);
    assign maj       = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign frame_bad = frm_err_r | ~maj;
    assign is_break  = all_zero & ~maj;
    assign last_stop = (STOP_BITS == 1) || stop_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            os_cnt     <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            samp_a     <= 1'b0;
            samp_b     <= 1'b0;
            data_sr    <= '0;
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            all_zero   <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end

            if (!rx_en) begin
                state  <= ST_IDLE;
                os_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_prev && !rx_sync) begin
                            state     <= ST_START;
                            os_cnt    <= '0;
                            bit_idx   <= '0;
                            stop_idx  <= 1'b0;
                            par_err_r <= 1'b0;
                            frm_err_r <= 1'b0;
                            all_zero  <= 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_sync) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (tick) begin
                            os_cnt <= (os_cnt == BIT_END) ? '0 : os_cnt + 1'b1;
                            if (os_cnt == SAMP0) samp_a <= rx_sync;
                            if (os_cnt == SAMP1) samp_b <= rx_sync;
                        end
                        case (state)
                            ST_START: begin
                                if (at_maj && maj) begin
                                    state <= ST_IDLE;
                                end else if (at_end) begin
                                    state <= ST_DATA;
                                end
                            end
                            ST_DATA: begin
                                if (at_maj) begin
                                    data_sr <= {maj, data_sr[DATA_BITS-1:1]};
                                    if (maj) all_zero <= 1'b0;
                                end
                                if (at_end) begin
                                    if (bit_idx == 4'(DATA_BITS - 1)) begin
                                        state <= (CHECK_MODE != CHK_NONE) ? ST_PARITY : ST_STOP;
                                    end else begin
                                        bit_idx <= bit_idx + 1'b1;
                                    end
                                end
                            end
                            ST_PARITY: begin
                                if (at_maj) begin
                                    par_err_r <= (maj != parity_bit(CHECK_MODE, 9'(data_sr)));
                                    if (maj) all_zero <= 1'b0;
                                end else if (at_end) begin
                                    state <= ST_STOP;
                                end
                            end
                            ST_STOP: begin
                                // The frame completes at the vote of the last stop bit.
                                if (at_maj && last_stop) begin
                                    if (m_valid && !m_ready) begin
                                        overrun <= 1'b1;
                                    end else begin
                                        m_data     <= data_sr;
                                        parity_err <= par_err_r;
                                        frame_err  <= frame_bad;
                                        m_valid    <= 1'b1;
                                    end
                                    break_det <= is_break;
                                    state     <= frame_bad ? ST_WAIT_IDLE : ST_IDLE;
                                end else if (at_maj) begin
                                    frm_err_r <= frame_bad;
                                    if (maj) all_zero <= 1'b0;
                                end else if (at_end) begin
                                    stop_idx <= 1'b1;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 27, meaning system clocks per oversample tick (>=1).
REQ-002 The block SHALL have parameter OS_RATE, default 16, meaning oversample ticks per bit (even, 8..32).
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-004 The block SHALL have parameter CHECK_MODE, default 1, meaning 0 none, 1 even, 2 odd, 3 fixed-0, 4 fixed-1.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-006 clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 rx_en  in  1  receiver enable; high active.
REQ-009 rx  in  1  serial line, asynchronous, idle high.
REQ-010 m_data  out  DATA_BITS  received word, LSB = first data bit.
REQ-011 m_valid  out  1  m_data and error flags valid; held until accepted.
REQ-012 m_ready  in  1  consumer accept; transfer when m_valid and m_ready are both high.
REQ-013 parity_err  out  1  parity mismatch for the word in m_data; 0 when CHECK_MODE=0.
REQ-014 frame_err  out  1  any stop bit sampled low for the word in m_data.
REQ-015 overrun  out  1  one-cycle pulse when a completed frame is dropped.
REQ-016 break_det  out  1  one-cycle pulse on break frame.

Function
REQ-017 rx SHALL pass through a 2-flop synchroniser; all decisions SHALL use the synchronised value.
REQ-018 Tick generator SHALL pulse once every CLK_DIV clocks, free-running while rx_en=1, cleared while rx_en=0.
REQ-019 Bit value SHALL be the majority of 3 samples taken at ticks OS_RATE/2-1, OS_RATE/2 and OS_RATE/2+1 of the bit.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-021 IDLE->START on a synchronised 1->0 edge; the tick counter restarts at 0 on that edge.
REQ-022 START: a majority value of 1 SHALL be treated as a false start -> IDLE with no output, else -> DATA at bit end.
REQ-023 DATA: DATA_BITS bits SHALL be shifted in LSB-first, then -> PARITY if CHECK_MODE!=0, else -> STOP.
REQ-024 Expected parity SHALL be: XOR of data (even), XNOR of data (odd), 0, or 1; mismatch sets parity_err.
REQ-025 STOP: STOP_BITS bits SHALL be sampled; any 0 sets frame_err; the frame completes at the mid-sample of the last stop bit.
REQ-026 Completion SHALL load m_data/parity_err/frame_err and assert m_valid on the next clk edge.
REQ-027 If m_valid=1 and m_ready=0 at completion, the new frame SHALL be dropped, the holding register SHALL be kept, and overrun SHALL pulse.
REQ-028 Acceptance and completion in the same cycle SHALL load the new frame with no overrun.
REQ-029 A frame with all data, parity and stop samples equal to 0 SHALL pulse break_det, SHALL be delivered with frame_err=1, and SHALL go to WAIT_IDLE.
REQ-030 WAIT_IDLE SHALL return to IDLE only after the synchronised rx reads 1; a frame with frame_err also goes to WAIT_IDLE.
REQ-031 rx_en=0 SHALL force IDLE within one cycle and abort any partial frame; the holding register and m_valid SHALL be unaffected.

Reset
REQ-032 On rst: FSM=IDLE, counters=0, m_data=0, m_valid=0, parity_err=0, frame_err=0, overrun=0, break_det=0, synchroniser flops=1.

Structure
REQ-033 Package uart_pkg SHALL hold the CHECK_MODE encodings, the FSM state encoding and a parity function; both RX and TX use it.
REQ-034 Sub-module uart_baud_tick (CLK_DIV counter, tick output, sync clear) SHALL be instantiated once.
REQ-035 Parameter legality SHALL be checked at elaboration; an illegal value is an elaboration error.

Verification
REQ-036 With CLK_DIV=4, OS_RATE=16, 8E1, send 0xA5 with parity 0 -> m_valid with m_data=0xA5, parity_err=0, frame_err=0.
REQ-037 Send 0x3C with parity bit 1 (even) -> m_data=0x3C, parity_err=1.
REQ-038 Apply a 20-clock low glitch on idle rx -> no m_valid and FSM back in IDLE.
REQ-039 Hold m_ready=0 and send 0x11 then 0x22 -> m_data stays 0x11 and overrun pulses once; then m_ready=1 -> one transfer.
REQ-040 Hold rx low for 15 bit times, then high -> one break_det pulse and m_data=0x00 with frame_err=1; no further frames until rx returns high.
REQ-041 Assert rst or drop rx_en mid-DATA, then send 0x5A -> only 0x5A is delivered and it is correct.
